// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small write FIFO so queued words leave back-to-back.
// Configurable data width, parity (none/odd/even), stop bits and baud divisor.
module uart_tx_fifo #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [DATA_BITS-1:0] Data,
  input  logic                 send_en,
  output logic                 ready,
  output logic                 uart_tx,
  output logic                 busy,
  output logic                 tx_done,
  output logic                 overflow,
  output logic [LW-1:0]        fifo_level
);
  localparam int MCNT_BAUD = CLOCK_FREQ / BAUD - 1;
  localparam int CW        = (MCNT_BAUD < 1) ? 1 : $clog2(MCNT_BAUD + 1);
  localparam int AW        = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY_S, STOP} state_t;

  state_t               state, state_d;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [LW-1:0]        level;
  logic [CW-1:0]        baud_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;
  logic                 full, wr_en, pop, bit_end, last_stop, line_d;

  assign full       = (level == LW'(FIFO_DEPTH));
  assign ready      = !full;
  assign wr_en      = send_en && !full;
  assign bit_end    = (baud_cnt == CW'(MCNT_BAUD));
  assign last_stop  = (state == STOP) && bit_end && (bit_cnt == 4'(STOP_BITS - 1));
  assign pop        = ((state == IDLE) || last_stop) && (level != '0);
  assign busy       = (state != IDLE) || (level != '0);
  assign fifo_level = level;

  always_comb begin
    state_d = state;
    line_d  = 1'b1;
    case (state)
      IDLE:     if (pop) state_d = START;
      START: begin
        line_d = 1'b0;
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        line_d = shift[0];
        if (bit_end && bit_cnt == 4'(DATA_BITS - 1))
          state_d = (PARITY != 0) ? PARITY_S : STOP;
      end
      PARITY_S: begin
        line_d = par_bit;
        if (bit_end) state_d = STOP;
      end
      STOP:     if (last_stop) state_d = pop ? START : IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Storage is left unreset; pointer reset is what discards the contents.
  always_ff @(posedge Clk) begin
    if (wr_en && !Reset) mem[wr_ptr] <= Data;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      uart_tx  <= 1'b1;
      tx_done  <= 1'b0;
      overflow <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
    end else begin
      state   <= state_d;
      uart_tx <= line_d;
      tx_done <= last_stop;
      if (send_en && full) overflow <= 1'b1;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        shift   <= mem[rd_ptr];
        par_bit <= (^mem[rd_ptr]) ^ (PARITY == 1);
      end
      level <= level + LW'(wr_en) - LW'(pop);
      // Counter is held at 0 in IDLE, so every START begins a fresh bit period.
      if (state == IDLE || bit_end) baud_cnt <= '0;
      else                          baud_cnt <= baud_cnt + 1'b1;
      if (state_d != state)  bit_cnt <= '0;
      else if (bit_end)      bit_cnt <= bit_cnt + 1'b1;
      if (state == DATA && bit_end) shift <= shift >> 1;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench: 8N1 depth-4 instance for FIFO/timing cases, plus 7E2 and 7O2
// instances driven together for parity framing.
module tb_uart_tx_fifo;
  logic       Clk = 0, Reset = 1, send_en = 0, send7 = 0;
  logic [7:0] Data = 0;
  logic [6:0] Data7 = 0;
  logic       ready, uart_tx, busy, tx_done, overflow;
  logic [2:0] fifo_level;
  logic       e_ready, e_tx, e_busy, e_done, e_ovf;
  logic [2:0] e_lvl;
  logic       o_ready, o_tx, o_busy, o_done, o_ovf;
  logic [2:0] o_lvl;
  int n_tests = 0, n_fail = 0;

  always #5 Clk = ~Clk;

  uart_tx_fifo #(.CLOCK_FREQ(50_000_000), .BAUD(5_000_000), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
    .Clk(Clk), .Reset(Reset), .Data(Data), .send_en(send_en), .ready(ready), .uart_tx(uart_tx),
    .busy(busy), .tx_done(tx_done), .overflow(overflow), .fifo_level(fifo_level));

  uart_tx_fifo #(.CLOCK_FREQ(50_000_000), .BAUD(5_000_000), .DATA_BITS(7), .PARITY(2),
                 .STOP_BITS(2), .FIFO_DEPTH(4)) dut_even (
    .Clk(Clk), .Reset(Reset), .Data(Data7), .send_en(send7), .ready(e_ready), .uart_tx(e_tx),
    .busy(e_busy), .tx_done(e_done), .overflow(e_ovf), .fifo_level(e_lvl));

  uart_tx_fifo #(.CLOCK_FREQ(50_000_000), .BAUD(5_000_000), .DATA_BITS(7), .PARITY(1),
                 .STOP_BITS(2), .FIFO_DEPTH(4)) dut_odd (
    .Clk(Clk), .Reset(Reset), .Data(Data7), .send_en(send7), .ready(o_ready), .uart_tx(o_tx),
    .busy(o_busy), .tx_done(o_done), .overflow(o_ovf), .fifo_level(o_lvl));

  typedef struct { logic [7:0] d; logic [9:0] line; } fvec_t;
  typedef struct { logic [6:0] d; logic [10:0] even_line; logic [10:0] odd_line; } pvec_t;

  task automatic step(input int n = 1);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Three writes on consecutive edges k, k+1, k+2; send_en left high.
  task automatic wr3(input logic [7:0] b);
    send_en = 1; Data = b;      step();
    Data = b + 8'd1;            step();
    Data = b + 8'd2;            step();
  endtask

  // Entered just after the edge where the first start bit hits the line (c=0).
  // Line bit i of a frame is stable from c=10i to c=10i+9; sample at the middle.
  task automatic run_frames(input string nm, input int n, input logic [9:0] exps [5],
                            input int extra, input logic [7:0] base,
                            input int late_c, input logic [7:0] late_d,
                            output int max_lvl, output bit saw_nr);
    int done_cnt = 0;
    int lvl_before = 0;
    max_lvl = 0; saw_nr = 0;
    for (int c = 0; c < n * 100 + 20; c++) begin
      if (c % 10 == 5) begin
        if (c < n * 100)
          chk($sformatf("%s f%0d bit%0d", nm, c / 100, (c % 100) / 10), uart_tx,
              exps[c / 100][(c % 100) / 10]);
        else
          chk($sformatf("%s idle line", nm), uart_tx, 1);
      end
      if (tx_done) begin
        done_cnt++;
        chk($sformatf("%s tx_done phase", nm), c % 100, 99);
      end
      if (c == n * 100 - 2) chk($sformatf("%s busy before end", nm), busy, 1);
      if (c == n * 100 - 1) chk($sformatf("%s busy at end", nm), busy, 0);
      if (late_c >= 0 && c == late_c) lvl_before = int'(fifo_level);
      if (late_c >= 0 && c == late_c + 1) begin
        chk($sformatf("%s level on write+pop", nm), fifo_level, lvl_before);
        chk($sformatf("%s overflow on write+pop", nm), overflow, 0);
      end
      if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
      if (!ready) saw_nr = 1;
      send_en = 0;
      if (c < extra) begin send_en = 1; Data = base + 8'(c); end
      if (c == late_c) begin send_en = 1; Data = late_d; end
      step();
    end
    chk($sformatf("%s tx_done count", nm), done_cnt, n);
  endtask

  task automatic send_one(input string nm, input fvec_t v);
    logic [9:0] ex [5];
    int ml; bit nr;
    ex = '{v.line, 10'h0, 10'h0, 10'h0, 10'h0};
    send_en = 1; Data = v.d; step(); send_en = 0;
    chk({nm, " lat k"}, uart_tx, 1);
    chk({nm, " busy k"}, busy, 1);
    step();
    chk({nm, " lat k+1"}, uart_tx, 1);
    step();
    chk({nm, " lat k+2"}, uart_tx, 0);
    run_frames(nm, 1, ex, 0, 8'h00, -1, 8'h00, ml, nr);
  endtask

  initial begin
    fvec_t fv [5];
    pvec_t pv [4];
    logic [9:0] ex [5];
    int ml, cnt_e, cnt_o, lows;
    bit nr;

    fv[0] = '{8'hA5, 10'b1101001010};
    fv[1] = '{8'h00, 10'b1000000000};
    fv[2] = '{8'hFF, 10'b1111111110};
    fv[3] = '{8'h01, 10'b1000000010};
    fv[4] = '{8'h80, 10'b1100000000};
    pv[0] = '{7'h55, 11'b11010101010, 11'b11110101010};
    pv[1] = '{7'h07, 11'b11100001110, 11'b11000001110};
    pv[2] = '{7'h7F, 11'b11111111110, 11'b11011111110};
    pv[3] = '{7'h00, 11'b11000000000, 11'b11100000000};

    // reset state
    step(2);
    chk("rst uart_tx", uart_tx, 1);
    chk("rst ready", ready, 1);
    chk("rst busy", busy, 0);
    chk("rst tx_done", tx_done, 0);
    chk("rst overflow", overflow, 0);
    chk("rst level", fifo_level, 0);
    Reset = 0;
    step(3);

    // single 8N1 frames
    for (int i = 0; i < 5; i++) send_one($sformatf("frame%0h", fv[i].d), fv[i]);

    // 7-bit, 2 stop bits, even and odd parity side by side (110-cycle frame)
    for (int i = 0; i < 4; i++) begin
      cnt_e = 0; cnt_o = 0;
      send7 = 1; Data7 = pv[i].d; step(); send7 = 0; step(2);
      for (int c = 0; c < 130; c++) begin
        if (c < 110 && c % 10 == 5) begin
          chk($sformatf("even %0h bit%0d", pv[i].d, c / 10), e_tx, pv[i].even_line[c / 10]);
          chk($sformatf("odd %0h bit%0d", pv[i].d, c / 10), o_tx, pv[i].odd_line[c / 10]);
        end
        if (e_done) begin cnt_e++; chk("even tx_done time", c, 109); end
        if (o_done) begin cnt_o++; chk("odd tx_done time", c, 109); end
        step();
      end
      chk("even tx_done count", cnt_e, 1);
      chk("odd tx_done count", cnt_o, 1);
    end

    // burst of 4 on consecutive edges: contiguous frames, level peaks at 3
    ex = '{10'b1010110100, 10'b1010110110, 10'b1010111000, 10'b1010111010, 10'h0};
    wr3(8'h5A);
    run_frames("burst", 4, ex, 1, 8'h5D, -1, 8'h00, ml, nr);
    chk("burst max level", ml, 3);
    chk("burst ready held", nr, 0);
    chk("burst overflow", overflow, 0);

    // write on the pop edge at end of stop with 3 queued
    ex = '{10'b1011000000, 10'b1011000010, 10'b1011000100, 10'b1011000110, 10'b1110000110};
    wr3(8'h60);
    run_frames("wrpop", 5, ex, 1, 8'h63, 98, 8'hC3, ml, nr);
    chk("wrpop max level", ml, 3);
    chk("wrpop overflow", overflow, 0);

    // hold send_en 8 cycles: 5 accepted, 3 dropped, overflow sticky
    ex = '{10'b1000100000, 10'b1000100010, 10'b1000100100, 10'b1000100110, 10'b1000101000};
    wr3(8'h10);
    run_frames("ovf", 5, ex, 5, 8'h13, -1, 8'h00, ml, nr);
    chk("ovf max level", ml, 4);
    chk("ovf ready dropped", nr, 1);
    chk("ovf sticky", overflow, 1);
    chk("ovf ready after", ready, 1);

    // reset during DATA of frame 2 of 3
    wr3(8'h20); send_en = 0;
    step(128);
    Reset = 1; step(); 
    chk("midrst uart_tx", uart_tx, 1);
    chk("midrst level", fifo_level, 0);
    chk("midrst busy", busy, 0);
    chk("midrst overflow", overflow, 0);
    chk("midrst ready", ready, 1);
    Reset = 0;
    cnt_e = 0; lows = 0;
    for (int c = 0; c < 150; c++) begin
      if (tx_done) cnt_e++;
      if (!uart_tx) lows++;
      step();
    end
    chk("midrst no tx_done", cnt_e, 0);
    chk("midrst line idle", lows, 0);
    send_one("after rst 3C", '{8'h3C, 10'b1001111000});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 sender in the oscilloscope datapath. Configurable data width, parity, stop bits and baud divisor. A small write FIFO decouples the sample/packet logic from line timing, so consecutive bytes go out back-to-back with no idle gap. Sits between the capture/packetiser logic and the FPGA TX pin.

Parameters:
CLOCK_FREQ, 50_000_000, system clock frequency in Hz
BAUD, 9600, line rate; bit period MCNT_BAUD = CLOCK_FREQ/BAUD - 1 (integer division)
DATA_BITS, 8, payload bits per frame, legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, legal 1 or 2
FIFO_DEPTH, 16, entries; power of two, >= 2

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
Data  in  DATA_BITS  byte to enqueue
send_en  in  1  write strobe; Data enqueued on this edge when ready=1
ready  out  1  FIFO not full
uart_tx  out  1  serial line, idle high
busy  out  1  frame in progress or FIFO non-empty
tx_done  out  1  one-cycle pulse at end of each frame's last stop bit
overflow  out  1  sticky; set when send_en is asserted while ready=0
fifo_level  out  $clog2(FIFO_DEPTH)+1  current entry count

Behaviour:
- Reset (Clk edge with Reset=1): uart_tx=1, ready=1, busy=0, tx_done=0, overflow=0, fifo_level=0, FSM=IDLE, baud and bit counters=0, FIFO pointers=0. Reset mid-frame aborts immediately. The line returns high on the next edge. FIFO contents are discarded.
- Reset has priority over all other events.
- FIFO: write when send_en && ready. Pop when FSM is IDLE, or on the final stop-bit cycle, and the FIFO is non-empty.
- Simultaneous write and pop on a non-full FIFO: fifo_level unchanged.
- Write while full is dropped and sets overflow, even if a pop happens on the same edge. overflow clears only on Reset.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on pop; the popped word is latched into the shift register.
  - START -> DATA after one bit period.
  - DATA shifts LSB first for DATA_BITS periods, then goes to PARITY if PARITY != 0, else STOP.
  - PARITY lasts one period, then STOP.
  - STOP lasts STOP_BITS periods. At its end the FSM goes to START if a pop occurs, else IDLE.
- Bit period: the baud counter runs 0..MCNT_BAUD while FSM != IDLE, so every bit is exactly MCNT_BAUD+1 cycles. The counter restarts at 0 on each START entry.
- uart_tx is registered: START=0, DATA=shift[0], PARITY=parity bit, STOP=1, IDLE=1.
- Parity: odd -> XOR of the data bits inverted; even -> XOR of the data bits. Computed from the latched word.
- Latency: send_en at edge k with FIFO empty and IDLE -> pop at edge k+1 -> uart_tx falls at edge k+2.
- Back-to-back: the next start bit begins on the cycle immediately after the last stop-bit cycle, with zero idle cycles.
- tx_done is asserted for exactly the one cycle following the final stop-bit cycle of each frame, including back-to-back frames.
- busy = (FSM != IDLE) || (fifo_level != 0).
- Frame length in bits = 1 + DATA_BITS + (PARITY != 0) + STOP_BITS.

Test Plan:
1. CLOCK_FREQ=50_000_000, BAUD=5_000_000 (10 clk/bit), 8N1; write 0xA5 -> uart_tx low 2 cycles after send_en. Line reads 0,1,0,1,0,0,1,0,1,1, each bit 10 cycles. One tx_done pulse 100 cycles after the start-bit edge.
2. 7 data bits, even parity, 2 stop bits; write 0x55 (four 1s) -> parity bit 0, frame 11 bits = 110 cycles. Odd parity on the same data -> parity bit 1.
3. Burst-write 4 bytes on 4 consecutive cycles -> fifo_level peaks at 3 (one popped immediately). Frames are contiguous with no idle cycle. 4 tx_done pulses, 100 cycles apart. busy falls with the last tx_done.
4. FIFO_DEPTH=4; hold send_en for 8 cycles while the first frame is active -> ready drops at level 4. The remaining writes are dropped and overflow latches 1. Exactly 5 frames are transmitted: 1 popped plus 4 queued.
5. Assert Reset during the DATA state of frame 2 of 3 -> the next edge gives uart_tx=1, fifo_level=0, busy=0, overflow=0. No tx_done follows. A subsequent write of 0x3C transmits correctly.
6. Write on the same edge as a pop at end of stop with FIFO_DEPTH-1 entries queued -> accepted. fifo_level is unchanged and overflow stays 0.
